fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID latch.
- Owns the program counter and issues instruction requests to the I-cache using the iREN/iaddr/ihit handshake.
- Delivers instruction, PC+4, write-enable and flush to IF/ID.
- Absorbs hazard stalls, branch/jump redirects (including redirects arriving mid-request) and halt.

Parameters:
PC0, 32'h0000_0000, PC value loaded at reset.
CNT_W, 32, width of the delivered-instruction counter.

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  output  1  instruction read request to I-cache
iaddr  output  32  instruction address (word_t); bits [1:0] always 00
ihit  input  1  I-cache data valid for current iaddr
imemload  input  32  instruction word from I-cache
stall  input  1  hazard unit: IF/ID must hold, PC must not advance
redirect_en  input  1  branch/jump resolved taken, 1-cycle pulse
redirect_pc  input  32  redirect target; bits [1:0] ignored
halt  input  1  halt decoded downstream, 1-cycle pulse
ifid_en  output  1  IF/ID write enable
imemload_out  output  32  instruction to IF/ID imemload_in
pcp4_out  output  32  PC+4 to IF/ID pcp4_in
flush  output  1  squash younger instruction held in IF/ID
halted  output  1  fetch stopped permanently until reset
fetch_cnt  output  CNT_W  count of instructions written into IF/ID

Behaviour:
- Reset (async, nRST=0):
  - pc=PC0, pend_pc=0, halt_pend=0, fetch_cnt=0, state=IDLE.
  - All outputs 0, except iaddr=PC0 and pcp4_out=PC0+4.
- States: IDLE, FETCH, REDIR_PEND, HALTED.
  - iREN=1 in FETCH and REDIR_PEND only.
  - iaddr=pc always.
  - pcp4_out=pc+4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
  - imemload_out=imemload, combinational pass-through.
- IDLE: one bubble cycle after reset release -> FETCH. Inputs ignored except halt, which sets halt_pend.
- Handshake: while iREN=1 and ihit=0, iaddr must not change. A redirect is never applied before the outstanding request completes.
- FETCH, priority order (highest first):
  - halt: flush=1, ifid_en=0.
    - If ihit=1 -> HALTED.
    - Otherwise set halt_pend and stay until ihit, then -> HALTED. Data is discarded.
  - redirect_en with ihit=1: flush=1, ifid_en=0, pc<=redirect_pc&~3. Stay FETCH. Next request goes out the following cycle.
  - redirect_en with ihit=0: flush=1, pend_pc<=redirect_pc&~3 -> REDIR_PEND.
  - ihit and !stall: ifid_en=1, pc<=pc+4, fetch_cnt++.
  - ihit and stall: ifid_en=0, pc holds, iREN stays 1. The request is re-hit next cycle.
  - !ihit: hold.
  - halt_pend=1 in FETCH with ihit -> HALTED. Takes priority over all the above.
- REDIR_PEND:
  - On ihit: data discarded, ifid_en=0, pc<=pend_pc -> FETCH.
  - A further redirect_en overwrites pend_pc (newest wins) and asserts flush=1 again.
  - If redirect_en and ihit coincide, the new target is loaded into pc.
  - halt here behaves as in FETCH; HALTED is entered on ihit.
- HALTED: iREN=0, halted=1, pc frozen. All inputs ignored. Exit only via reset.
- flush is combinational, asserted only in the cycles listed above. ifid_en and flush are never both 1.
- stall never blocks flush or redirect capture.
- fetch_cnt wraps at 2^CNT_W.
- Reset mid-request: immediate return to the reset state. No handshake obligation survives reset.

Decomposition:
- cpu_types_pkg: word_t and WORD_W (existing). Add fetch_state_t enum {IDLE, FETCH, REDIR_PEND, HALTED} and PC_INC=4.
- Sub-module pc_reg: holds pc and pend_pc, with load/inc/hold controls and async reset to PC0.
- fetch_unit: FSM, handshake logic and counter.

Test Plan:
- Reset release, ihit tied 1, no stall: iaddr sequence 0,0,4,8,C (first 0 is the IDLE bubble); ifid_en=1 from cycle 2; fetch_cnt=3 after 3 hits.
- ihit low 3 cycles at iaddr 8 with redirect_en=1, redirect_pc=0x103 on cycle 1:
  - iaddr stays 8 until ihit.
  - flush=1 on redirect cycle.
  - ihit data discarded (ifid_en=0).
  - Next iaddr=0x100.
- In REDIR_PEND, second redirect to 0x200 before ihit: pending target becomes 0x200; next fetch after ihit is 0x200; fetch_cnt unchanged.
- stall=1 for 2 cycles with ihit=1 at iaddr 0x10: ifid_en=0, iaddr holds 0x10; after release ifid_en=1 once, iaddr->0x14.
- halt with ihit=0: iREN stays 1 until ihit, then iREN=0, halted=1; later redirect_en/ihit pulses change nothing.
- PC0=32'hFFFF_FFFC: first delivered pcp4_out=0, next iaddr=0. Asserting nRST=0 mid-wait: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the PC step size.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   // Sequential fetch advances by one 32-bit instruction
   localparam word_t PC_INC = 32'd4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      REDIR_PEND,
      HALTED
   } fetch_state_t;

   // Instruction addresses are always word aligned; low two bits are dropped
   function automatic word_t align_word(input word_t addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter plus the pending redirect target captured while a
// request is still outstanding at the I-cache.
module pc_reg
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC0 = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        i_load,
   input  logic [31:0] i_load_pc,
   input  logic        i_inc,
   input  logic        i_pend_we,
   input  logic [31:0] i_pend_pc,
   output logic [31:0] o_pc,
   output logic [31:0] o_pend_pc
);

   logic [31:0] r_pc;
   logic [31:0] r_pend_pc;

   // PC update: an explicit load outranks the sequential increment
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc      <= align_word(PC0);
         r_pend_pc <= '0;
      end else begin
         if (i_load) begin
            r_pc <= align_word(i_load_pc);
         end else if (i_inc) begin
            r_pc <= r_pc + PC_INC;
         end
         if (i_pend_we) begin
            r_pend_pc <= align_word(i_pend_pc);
         end
      end
   end

   assign o_pc      = r_pc;
   assign o_pend_pc = r_pend_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the I-cache request
// handshake and feeds the IF/ID latch, honouring stalls, redirects and halt.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC0   = 32'h0000_0000,
   parameter int          CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             ihit,
   input  logic [31:0]      imemload,
   input  logic             stall,
   input  logic             redirect_en,
   input  logic [31:0]      redirect_pc,
   input  logic             halt,
   output logic             ifid_en,
   output logic [31:0]      imemload_out,
   output logic [31:0]      pcp4_out,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   fetch_state_t     r_state;
   logic             r_halt_pend;
   logic [CNT_W-1:0] r_fetch_cnt;

   logic        w_busy;
   logic        w_halting;
   logic        w_load;
   logic [31:0] w_load_pc;
   logic        w_inc;
   logic        w_pend_we;
   logic        w_deliver;
   logic [31:0] w_pc;
   logic [31:0] w_pend_pc;

   // A request is outstanding whenever we are fetching or draining a redirect
   assign w_busy    = (r_state == FETCH) || (r_state == REDIR_PEND);
   // A fresh halt pulse and a remembered one both freeze the PC
   assign w_halting = halt || r_halt_pend;

   pc_reg #(
      .PC0 (PC0)
   ) u_pc_reg (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_load    (w_load),
      .i_load_pc (w_load_pc),
      .i_inc     (w_inc),
      .i_pend_we (w_pend_we),
      .i_pend_pc (redirect_pc),
      .o_pc      (w_pc),
      .o_pend_pc (w_pend_pc)
   );

   // PC control decode; a redirect only moves the PC on the cycle the
   // outstanding request completes, so iaddr is stable while waiting
   always_comb begin
      w_load    = 1'b0;
      w_load_pc = redirect_pc;
      w_inc     = 1'b0;
      w_pend_we = 1'b0;
      w_deliver = 1'b0;
      case (r_state)
         FETCH: begin
            if (!w_halting) begin
               if (redirect_en) begin
                  if (ihit) begin
                     w_load = 1'b1;
                  end else begin
                     w_pend_we = 1'b1;
                  end
               end else if (ihit && !stall) begin
                  w_deliver = 1'b1;
                  w_inc     = 1'b1;
               end
            end
         end
         REDIR_PEND: begin
            if (!w_halting) begin
               if (ihit) begin
                  w_load    = 1'b1;
                  w_load_pc = redirect_en ? redirect_pc : w_pend_pc;
               end else if (redirect_en) begin
                  w_pend_we = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Fetch state machine, halt latch and delivered-instruction counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_halt_pend <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= FETCH;
               if (halt) begin
                  r_halt_pend <= 1'b1;
               end
            end
            FETCH: begin
               if (w_halting) begin
                  if (ihit) begin
                     r_state <= HALTED;
                  end else begin
                     r_halt_pend <= 1'b1;
                  end
               end else if (redirect_en && !ihit) begin
                  r_state <= REDIR_PEND;
               end
            end
            REDIR_PEND: begin
               if (w_halting) begin
                  if (ihit) begin
                     r_state <= HALTED;
                  end else begin
                     r_halt_pend <= 1'b1;
                  end
               end else if (ihit) begin
                  r_state <= FETCH;
               end
            end
            default: begin
               r_state <= HALTED;
            end
         endcase
         if (w_deliver) begin
            r_fetch_cnt <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign iREN         = w_busy;
   assign iaddr        = w_pc;
   assign pcp4_out     = w_pc + PC_INC;
   assign imemload_out = imemload;
   assign ifid_en      = w_deliver;
   assign flush        = w_busy && (halt || redirect_en);
   assign halted       = (r_state == HALTED);
   assign fetch_cnt    = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all continuously compared against a behavioural model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] imemload = '0;
   logic        stall = 1'b0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;

   logic        iREN, ifid_en, flush, halted;
   logic [31:0] iaddr, imemload_out, pcp4_out, fetch_cnt;

   logic        iREN_w, ifid_en_w, flush_w, halted_w;
   logic [31:0] iaddr_w, imemload_out_w, pcp4_out_w, fetch_cnt_w;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   logic        m_started, m_halted, m_hpend, m_rvalid;
   logic [31:0] m_pc, m_pend, m_cnt;
   logic        e_busy, e_ifid;

   fetch_unit #(.PC0(32'h0000_0000), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
      .imemload(imemload), .stall(stall), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .halt(halt), .ifid_en(ifid_en),
      .imemload_out(imemload_out), .pcp4_out(pcp4_out), .flush(flush),
      .halted(halted), .fetch_cnt(fetch_cnt)
   );

   fetch_unit #(.PC0(32'hFFFF_FFFC), .CNT_W(32)) dut_w (
      .CLK(CLK), .nRST(nRST), .iREN(iREN_w), .iaddr(iaddr_w), .ihit(ihit),
      .imemload(imemload), .stall(stall), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .halt(halt), .ifid_en(ifid_en_w),
      .imemload_out(imemload_out_w), .pcp4_out(pcp4_out_w), .flush(flush_w),
      .halted(halted_w), .fetch_cnt(fetch_cnt_w)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_halted  = 1'b0;
      m_hpend   = 1'b0;
      m_rvalid  = 1'b0;
      m_pc      = 32'h0;
      m_pend    = 32'h0;
      m_cnt     = 32'h0;
   endtask

   // one clock of the fetch rules: what the PC, count and halt status become
   task automatic model_step();
      logic [31:0] tgt;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (!m_started) begin
         m_started = 1'b1;
         if (halt) m_hpend = 1'b1;
      end else if (!m_halted) begin
         if (halt || m_hpend) begin
            if (ihit) m_halted = 1'b1;
            else      m_hpend  = 1'b1;
         end else if (m_rvalid) begin
            if (ihit) begin
               m_pc     = redirect_en ? tgt : m_pend;
               m_rvalid = 1'b0;
            end else if (redirect_en) begin
               m_pend = tgt;
            end
         end else if (redirect_en) begin
            if (ihit) m_pc = tgt;
            else begin
               m_rvalid = 1'b1;
               m_pend   = tgt;
            end
         end else if (ihit && !stall) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK);
         if (!nRST) model_reset();
         else       model_step();
      end
   end

   // compare every cycle on the falling edge
   initial begin
      forever begin
         @(negedge CLK);
         e_busy = m_started && !m_halted;
         e_ifid = e_busy && !m_rvalid && !m_hpend && !halt && !redirect_en && ihit && !stall;
         chk("m_iREN",    32'(iREN),    32'(e_busy));
         chk("m_iaddr",   iaddr,        m_pc);
         chk("m_pcp4",    pcp4_out,     m_pc + 32'd4);
         chk("m_ifid_en", 32'(ifid_en), 32'(e_ifid));
         chk("m_flush",   32'(flush),   32'(e_busy && (halt || redirect_en)));
         chk("m_halted",  32'(halted),  32'(m_halted));
         chk("m_cnt",     fetch_cnt,    m_cnt);
         chk("m_imem",    imemload_out, imemload);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input logic ih, input logic st, input logic re,
                         input logic [31:0] rpc, input logic hl);
      ihit        = ih;
      stall       = st;
      redirect_en = re;
      redirect_pc = rpc;
      halt        = hl;
      imemload    = $urandom;
   endtask

   task automatic apply_reset();
      nRST = 1'b0;
      model_reset();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      // startup with ihit tied high
      apply_reset();
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t1_idle_iaddr", iaddr, 32'h0);
      chk("t1_idle_iren", 32'(iREN), 32'h0);
      chk("t1_idle_ifid", 32'(ifid_en), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         chk("t1_iaddr_seq", iaddr, 32'(4 * i));
         if (i < 3) chk("t1_ifid", 32'(ifid_en), 32'h1);
      end
      chk("t1_cnt3", fetch_cnt, 32'd3);

      // redirect-with-hit back to 8
      set_in(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
      step();

      // redirect arriving while the request at 8 is still waiting
      set_in(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
      #1;
      chk("t2_flush", 32'(flush), 32'h1);
      chk("t2_ifid", 32'(ifid_en), 32'h0);
      chk("t2_iaddr_hold", iaddr, 32'h8);
      step();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t2_iaddr_hold2", iaddr, 32'h8);
      chk("t2_flush_off", 32'(flush), 32'h0);
      step();
      #1;
      chk("t2_iaddr_hold3", iaddr, 32'h8);
      step();
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t2_discard", 32'(ifid_en), 32'h0);
      step();
      #1;
      chk("t2_new_iaddr", iaddr, 32'h100);

      // newest pending redirect wins
      set_in(1'b0, 1'b0, 1'b1, 32'h180, 1'b0);
      step();
      set_in(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
      #1;
      chk("t3_flush2", 32'(flush), 32'h1);
      step();
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t3_discard", 32'(ifid_en), 32'h0);
      chk("t3_iaddr_hold", iaddr, 32'h100);
      step();
      #1;
      chk("t3_iaddr", iaddr, 32'h200);
      chk("t3_cnt", fetch_cnt, 32'd3);

      // stall with ihit high at 0x10
      set_in(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
      step();
      set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t4_stall_ifid", 32'(ifid_en), 32'h0);
         chk("t4_stall_iaddr", iaddr, 32'h10);
         chk("t4_stall_iren", 32'(iREN), 32'h1);
         step();
      end
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t4_release_ifid", 32'(ifid_en), 32'h1);
      step();
      #1;
      chk("t4_iaddr", iaddr, 32'h14);
      chk("t4_cnt", fetch_cnt, 32'd4);

      // halt while the request is waiting
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      chk("t5_flush", 32'(flush), 32'h1);
      chk("t5_iren", 32'(iREN), 32'h1);
      step();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t5_iren_wait", 32'(iREN), 32'h1);
      chk("t5_not_halted", 32'(halted), 32'h0);
      step();
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t5_hit_ifid", 32'(ifid_en), 32'h0);
      step();
      #1;
      chk("t5_iren_off", 32'(iREN), 32'h0);
      chk("t5_halted", 32'(halted), 32'h1);
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
         step();
         #1;
         chk("t5_frozen_iaddr", iaddr, 32'h14);
         chk("t5_frozen_halted", 32'(halted), 32'h1);
         chk("t5_frozen_flush", 32'(flush), 32'h0);
      end

      // PC wrap on the second instance, then async reset mid-wait
      apply_reset();
      #1;
      chk("t6_w_iaddr0", iaddr_w, 32'hFFFF_FFFC);
      chk("t6_w_pcp4_0", pcp4_out_w, 32'h0);
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      #1;
      chk("t6_w_ifid", 32'(ifid_en_w), 32'h1);
      chk("t6_w_pcp4", pcp4_out_w, 32'h0);
      step();
      #1;
      chk("t6_w_iaddr_wrap", iaddr_w, 32'h0);
      chk("t6_w_pcp4_next", pcp4_out_w, 32'h4);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      step();
      #1;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_iren", 32'(iREN), 32'h0);
      chk("t6_rst_iaddr", iaddr, 32'h0);
      chk("t6_rst_pcp4", pcp4_out, 32'h4);
      chk("t6_rst_cnt", fetch_cnt, 32'h0);
      chk("t6_rst_w_iren", 32'(iREN_w), 32'h0);
      chk("t6_rst_w_iaddr", iaddr_w, 32'hFFFF_FFFC);
      chk("t6_rst_w_cnt", fetch_cnt_w, 32'h0);
      chk("t6_rst_w_halted", 32'(halted_w), 32'h0);

      // randomized traffic
      apply_reset();
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 199) == 0);
         step();
         if (m_halted && ($urandom_range(0, 3) == 0)) apply_reset();
      end

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
